// File: rtl/reg_array_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : reg_array_arbiter
// Purpose  : Two-port round-robin arbiter and sequencer for the K2 register
//            array. Serialises requester transactions onto the single array
//            access port using an IDLE -> ACCESS -> RESP sequence.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            req0/1, we0/1          - request and write/read select per port
//            addr0/1, wdata0/1      - target register and write data per port
//            ack0/1, rdata0/1       - one-cycle completion pulse, read data
//            ra_R_W, ra_select,     - array write strobe, select, write data
//            ra_d
//            ra_q                   - registered array read data
//            busy, gnt_id           - transaction in flight, granted port
// Revision : 1.0 - initial release
// ============================================================================
module reg_array_arbiter #(
    parameter int bits              = 8,
    parameter int array_select_size = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req0,
    input  logic                         req1,
    input  logic                         we0,
    input  logic                         we1,
    input  logic [array_select_size-1:0] addr0,
    input  logic [array_select_size-1:0] addr1,
    input  logic [bits-1:0]              wdata0,
    input  logic [bits-1:0]              wdata1,
    output logic                         ack0,
    output logic                         ack1,
    output logic [bits-1:0]              rdata0,
    output logic [bits-1:0]              rdata1,
    output logic                         ra_R_W,
    output logic [array_select_size-1:0] ra_select,
    output logic [bits-1:0]              ra_d,
    input  logic [bits-1:0]              ra_q,
    output logic                         busy,
    output logic                         gnt_id
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                         state_q,      state_d;
    logic                           last_grant_q, last_grant_d;
    logic                           gnt_id_q,     gnt_id_d;
    logic [array_select_size-1:0]   addr_q,       addr_d;
    logic [bits-1:0]                wdata_q,      wdata_d;
    logic                           wstrobe_q,    wstrobe_d;
    logic                           ack0_q,       ack0_d;
    logic                           ack1_q,       ack1_d;
    logic                           busy_q,       busy_d;

    logic                           w_any_req;
    logic                           w_winner;

    // Round-robin pick: a lone requester always wins; on a tie the port that
    // was not granted last time wins.
    always_comb begin
        w_any_req = req0 | req1;
        if (req0 && req1) begin
            w_winner = ~last_grant_q;
        end else begin
            w_winner = req1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrobe_d    = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (w_any_req) begin
                    // Payload is captured here so the array port sees a
                    // stable select/data even if the requester misbehaves.
                    state_d      = ST_ACCESS;
                    last_grant_d = w_winner;
                    gnt_id_d     = w_winner;
                    addr_d       = w_winner ? addr1  : addr0;
                    wdata_d      = w_winner ? wdata1 : wdata0;
                    // Strobe is registered so it is high exactly during ACCESS.
                    wstrobe_d    = w_winner ? we1    : we0;
                    busy_d       = 1'b1;
                end
            end

            ST_ACCESS: begin
                // The array commits the write / captures ra_q at the end of
                // this cycle; the ack lands in RESP alongside that data.
                state_d = ST_RESP;
                ack0_d  = ~gnt_id_q;
                ack1_d  = gnt_id_q;
                busy_d  = 1'b1;
            end

            ST_RESP: begin
                // No arbitration here: a req seen now is handled from IDLE.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;      // requester 0 wins the first tie
            gnt_id_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrobe_q    <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrobe_q    <= wstrobe_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    // ra_q already holds the value captured at the end of ACCESS; gate it so
    // the idle port always reads zero.
    assign rdata0    = ack0_q ? ra_q : '0;
    assign rdata1    = ack1_q ? ra_q : '0;
    assign ra_R_W    = wstrobe_q;
    assign ra_select = addr_q;
    assign ra_d      = wdata_q;
    assign busy      = busy_q;
    assign gnt_id    = gnt_id_q;

endmodule
`default_nettype wire
